// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and command codes for the pipeline run/step/stop
//               sequencer (state encoding, debug command codes, helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

   // Sequencer states; IDLE is the reset state.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STEP   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Debug command codes carried on i_cmd.
   localparam logic [1:0] CMD_CLEAR = 2'b00;
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_STOP  = 2'b11;

   // The pipeline advances only in RUN and STEP.
   function automatic logic state_enables_pipe(input state_t s);
      return (s == ST_RUN) || (s == ST_STEP);
   endfunction

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : W-bit up counter with synchronous clear that sticks at
//               all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // Clear has priority; increment stops once every bit is set.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + {{(W-1){1'b0}}, 1'b1};
      end
   end

   assign q = r_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_run_ctrl
// Description : Run/step/stop sequencer for the five-stage MIPS pipeline.
//               Drives the global pipeline enable, executes debug commands
//               over a valid/ready channel, freezes on a retired halt and
//               counts enabled cycles.
//               Optional watchdog: define PIPE_CTRL_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_run_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int          CNT_W      = 32,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   input  logic [1:0]       i_cmd,
   output logic             o_cmd_ready,
   input  logic             i_Halt,
   output logic             o_pipe_en,
   output logic             o_busy,
   output logic             o_halted,
   output logic             o_step_done,
   output logic             o_cmd_err,
   output logic [CNT_W-1:0] o_cycle_cnt,
   output logic             o_timeout
);

   state_t           r_state;
   logic             r_pipe_en;
   logic             r_busy;
   logic             r_halted;
   logic             r_cmd_ready;
   logic             r_step_done;
   logic             r_cmd_err;

   state_t           w_next;
   logic             w_accept;
   logic             w_clr;
   logic             w_err;
   logic             w_done;
   logic             w_wd_hit;
   logic [CNT_W-1:0] w_cnt;

   assign w_accept = i_cmd_valid && r_cmd_ready;

`ifdef PIPE_CTRL_WATCHDOG_EN
   logic r_timeout;

   // Counter is still at MAX_CYCLES-1 in the last enabled cycle before the limit.
   assign w_wd_hit = (w_cnt == CNT_W'(MAX_CYCLES - 32'd1));

   // Timeout is sticky until the HALTED state is cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_timeout <= 1'b0;
      end else if ((r_state == ST_RUN) && w_wd_hit) begin
         r_timeout <= 1'b1;
      end else if (w_clr) begin
         r_timeout <= 1'b0;
      end
   end

   assign o_timeout = r_timeout;
`else
   logic w_unused_max;

   assign w_wd_hit     = 1'b0;
   assign w_unused_max = ^MAX_CYCLES;
   assign o_timeout    = 1'b0;
`endif

   // Next-state and event decode; a halt (or watchdog) in RUN outranks STOP.
   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_err  = 1'b0;
      w_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (i_cmd)
                  CMD_RUN:   w_next = ST_RUN;
                  CMD_STEP:  w_next = ST_STEP;
                  CMD_CLEAR: w_clr  = 1'b1;
                  default:   w_err  = 1'b1;
               endcase
            end
         end
         ST_RUN: begin
            if (w_wd_hit || i_Halt) begin
               w_next = ST_HALTED;
            end else if (w_accept && (i_cmd == CMD_STOP)) begin
               w_next = ST_IDLE;
            end
            if (w_accept && (i_cmd != CMD_STOP)) begin
               w_err = 1'b1;
            end
         end
         ST_STEP: begin
            if (i_Halt) begin
               w_next = ST_HALTED;
            end else begin
               w_next = ST_IDLE;
               w_done = 1'b1;
            end
         end
         ST_HALTED: begin
            if (w_accept) begin
               if (i_cmd == CMD_CLEAR) begin
                  w_next = ST_IDLE;
                  w_clr  = 1'b1;
               end else begin
                  w_err = 1'b1;
               end
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register with all status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_pipe_en   <= 1'b0;
         r_busy      <= 1'b0;
         r_halted    <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_step_done <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_pipe_en   <= state_enables_pipe(w_next);
         r_busy      <= state_enables_pipe(w_next);
         r_halted    <= (w_next == ST_HALTED);
         r_cmd_ready <= (w_next != ST_STEP);
         r_step_done <= w_done;
         r_cmd_err   <= w_err;
      end
   end

   sat_counter #(
      .W   (CNT_W)
   ) u_cycle_cnt (
      .clk (clk),
      .rst (rst),
      .clr (w_clr),
      .inc (r_pipe_en),
      .q   (w_cnt)
   );

   assign o_cmd_ready = r_cmd_ready;
   assign o_pipe_en   = r_pipe_en;
   assign o_busy      = r_busy;
   assign o_halted    = r_halted;
   assign o_step_done = r_step_done;
   assign o_cmd_err   = r_cmd_err;
   assign o_cycle_cnt = w_cnt;

endmodule : pipeline_run_ctrl
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_run_ctrl
// Description : Scoreboard bench for pipeline_run_ctrl. Each driven cycle
//               pushes the expected registered outputs; they are popped and
//               compared one time unit after the following rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_run_ctrl;
   import pipe_ctrl_pkg::*;

   localparam int          CW   = 8;
   localparam logic [31:0] MAXC = 32'd20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_cmd_valid = 1'b0;
   logic [1:0]    i_cmd = 2'b00;
   logic          i_Halt = 1'b0;
   logic          o_cmd_ready;
   logic          o_pipe_en;
   logic          o_busy;
   logic          o_halted;
   logic          o_step_done;
   logic          o_cmd_err;
   logic [CW-1:0] o_cycle_cnt;
   logic          o_timeout;

   always #5 clk = ~clk;

   pipeline_run_ctrl #(
      .CNT_W       (CW),
      .MAX_CYCLES  (MAXC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_cmd_valid (i_cmd_valid),
      .i_cmd       (i_cmd),
      .o_cmd_ready (o_cmd_ready),
      .i_Halt      (i_Halt),
      .o_pipe_en   (o_pipe_en),
      .o_busy      (o_busy),
      .o_halted    (o_halted),
      .o_step_done (o_step_done),
      .o_cmd_err   (o_cmd_err),
      .o_cycle_cnt (o_cycle_cnt),
      .o_timeout   (o_timeout)
   );

   typedef struct packed {
      logic          rdy;
      logic          en;
      logic          busy;
      logic          hlt;
      logic          done;
      logic          err;
      logic          to;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            n_en_seen = 0;

   // Reference state: 0 IDLE, 1 RUN, 2 STEP, 3 HALTED
   int            m_st = 0;
   logic [CW-1:0] m_cnt = '0;
   logic          m_to = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic done, input logic err);
      exp_t e;
      e.rdy  = (m_st != 2);
      e.en   = (m_st == 1) || (m_st == 2);
      e.busy = (m_st == 1) || (m_st == 2);
      e.hlt  = (m_st == 3);
      e.done = done;
      e.err  = err;
      e.to   = m_to;
      e.cnt  = m_cnt;
      sb_q.push_back(e);
   endtask

   // Advance the reference by one cycle given the inputs driven for it.
   task automatic model_step(input logic v, input logic [1:0] c, input logic h);
      int   nst;
      logic clr, done, err, acc, en, wd;
      en  = (m_st == 1) || (m_st == 2);
      acc = v && (m_st != 2);
      nst = m_st;
      clr = 1'b0; done = 1'b0; err = 1'b0; wd = 1'b0;
      case (m_st)
         0: if (acc) begin
               if (c == CMD_RUN) nst = 1;
               else if (c == CMD_STEP) nst = 2;
               else if (c == CMD_CLEAR) clr = 1'b1;
               else err = 1'b1;
            end
         1: begin
`ifdef PIPE_CTRL_WATCHDOG_EN
               wd = (m_cnt == CW'(MAXC - 32'd1));
`endif
               if (wd) begin
                  nst  = 3;
                  m_to = 1'b1;
               end else if (h) begin
                  nst = 3;
               end else if (acc && c == CMD_STOP) begin
                  nst = 0;
               end
               if (acc && c != CMD_STOP) err = 1'b1;
            end
         2: begin
               nst  = h ? 3 : 0;
               done = !h;
            end
         default: if (acc) begin
               if (c == CMD_CLEAR) begin
                  nst  = 0;
                  clr  = 1'b1;
                  m_to = 1'b0;
               end else begin
                  err = 1'b1;
               end
            end
      endcase
      if (clr) m_cnt = '0;
      else if (en && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      m_st = nst;
      push_exp(done, err);
   endtask

   task automatic compare_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val("cmd_ready", {31'd0, o_cmd_ready}, {31'd0, e.rdy});
         check_val("pipe_en",   {31'd0, o_pipe_en},   {31'd0, e.en});
         check_val("busy",      {31'd0, o_busy},      {31'd0, e.busy});
         check_val("halted",    {31'd0, o_halted},    {31'd0, e.hlt});
         check_val("step_done", {31'd0, o_step_done}, {31'd0, e.done});
         check_val("cmd_err",   {31'd0, o_cmd_err},   {31'd0, e.err});
         check_val("timeout",   {31'd0, o_timeout},   {31'd0, e.to});
         check_val("cycle_cnt", {{(32-CW){1'b0}}, o_cycle_cnt}, {{(32-CW){1'b0}}, e.cnt});
      end
      if (o_pipe_en) n_en_seen++;
   endtask

   task automatic cycle(input logic v, input logic [1:0] c, input logic h);
      i_cmd_valid = v;
      i_cmd       = c;
      i_Halt      = h;
      model_step(v, c, h);
      @(posedge clk);
      #1;
      compare_out();
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd       = CMD_CLEAR;
      i_Halt      = 1'b0;
      m_st  = 0;
      m_cnt = '0;
      m_to  = 1'b0;
      push_exp(1'b0, 1'b0);
      @(posedge clk);
      #1;
      compare_out();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      do_reset();

      // RUN, halt retires in the 10th enabled cycle
      n_en_seen = 0;
      cycle(1'b1, CMD_RUN, 1'b0);
      repeat (9) cycle(1'b0, CMD_CLEAR, 1'b0);
      cycle(1'b0, CMD_CLEAR, 1'b1);
      check_val("halt_en_cycles", n_en_seen, 32'd10);
      check_val("halt_cnt", {24'd0, o_cycle_cnt}, 32'd10);
      check_val("halt_flag", {31'd0, o_halted}, 32'd1);
      cycle(1'b0, CMD_CLEAR, 1'b1);

      // HALTED: RUN is illegal, CLEAR returns to IDLE and zeroes the count
      cycle(1'b1, CMD_RUN, 1'b0);
      cycle(1'b1, CMD_CLEAR, 1'b0);
      check_val("clear_cnt", {24'd0, o_cycle_cnt}, 32'd0);

      // Three steps; the command held during STEP is not accepted
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, CMD_STEP, 1'b0);
         cycle(1'b1, CMD_STEP, 1'b0);
      end
      cycle(1'b0, CMD_CLEAR, 1'b0);
      check_val("step_cnt", {24'd0, o_cycle_cnt}, 32'd3);

      // Step that retires a halt: HALTED, no step_done
      cycle(1'b1, CMD_STEP, 1'b0);
      cycle(1'b0, CMD_CLEAR, 1'b1);
      cycle(1'b1, CMD_CLEAR, 1'b0);

      // STOP in IDLE is illegal; CLEAR in IDLE is fine
      cycle(1'b1, CMD_STOP, 1'b0);
      cycle(1'b1, CMD_CLEAR, 1'b0);

      // STOP together with halt in RUN: halt wins, no error
      cycle(1'b1, CMD_RUN, 1'b0);
      repeat (3) cycle(1'b0, CMD_CLEAR, 1'b0);
      cycle(1'b1, CMD_STOP, 1'b1);
      check_val("stop_halt_err", {31'd0, o_cmd_err}, 32'd0);
      cycle(1'b1, CMD_CLEAR, 1'b0);

      // Plain STOP from RUN, plus illegal RUN/STEP inside RUN
      cycle(1'b1, CMD_RUN, 1'b0);
      cycle(1'b1, CMD_RUN, 1'b0);
      cycle(1'b1, CMD_STEP, 1'b0);
      cycle(1'b1, CMD_STOP, 1'b0);
      cycle(1'b0, CMD_CLEAR, 1'b1);
      cycle(1'b1, CMD_CLEAR, 1'b0);

`ifndef PIPE_CTRL_WATCHDOG_EN
      // Reset mid-RUN at count 57
      cycle(1'b1, CMD_RUN, 1'b0);
      repeat (57) cycle(1'b0, CMD_CLEAR, 1'b0);
      check_val("cnt57", {24'd0, o_cycle_cnt}, 32'd57);
      do_reset();
      check_val("rst_pipe_en", {31'd0, o_pipe_en}, 32'd0);
      check_val("rst_cnt", {24'd0, o_cycle_cnt}, 32'd0);

      // Counter saturation
      cycle(1'b1, CMD_RUN, 1'b0);
      repeat (260) cycle(1'b0, CMD_CLEAR, 1'b0);
      check_val("sat_cnt", {24'd0, o_cycle_cnt}, 32'd255);
      cycle(1'b1, CMD_STOP, 1'b0);
      cycle(1'b1, CMD_CLEAR, 1'b0);
`else
      // Watchdog: RUN with no halt stops at MAX_CYCLES enabled cycles
      cycle(1'b1, CMD_RUN, 1'b0);
      repeat (25) cycle(1'b0, CMD_CLEAR, 1'b0);
      check_val("wd_timeout", {31'd0, o_timeout}, 32'd1);
      check_val("wd_halted", {31'd0, o_halted}, 32'd1);
      check_val("wd_cnt", {24'd0, o_cycle_cnt}, 32'd20);
      cycle(1'b1, CMD_CLEAR, 1'b0);
      check_val("wd_cleared", {31'd0, o_timeout}, 32'd0);
`endif

      check_val("sb_drained", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pipeline_run_ctrl
`default_nettype wire
